// File: rtl/capture_seg_unit.sv
// ---------------------------------------------------------------------------
// capture_seg_unit
//   Segmented capture controller for the logic-analyzer sample RAM.
//   The RAM is split into 2^nseg_l2 equal segments. Each segment records
//   at least TH pre-trigger samples, one trigger sample and tp
//   post-trigger samples, then the unit moves on to the next segment.
//   It raises capture_done once the last segment is full.
//
// Parameters
//   ENTRIES       total RAM depth; a multiple of 2^SEG_LOG2_MAX
//   ADDR_W        RAM address width (2^ADDR_W >= ENTRIES)
//   SEG_LOG2_MAX  largest supported log2 segment count (>= 1)
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   run           start pulse (accepted only in IDLE or DONE)
//   abort         return to IDLE; takes priority over run
//   wrt_smpl      sample-valid strobe
//   triggered     qualified trigger (only looked at together with wrt_smpl)
//   trig_pos      post-trigger samples per segment
//   seg_log2      log2 of the requested segment count
//   waddr         registered RAM write address
//   write         RAM write enable (combinational)
//   armed         waiting for a trigger
//   seg_done      one-cycle pulse after a segment completes
//   cur_seg       segment currently being filled
//   trig_addr     address of the last trigger sample
//   capture_done  all segments filled
//   busy          capture in progress (PRE, ARMED, POST)
//   seg_tstamp    cycle count of the trigger, shown with seg_done
//                 (present only with CAPT_SEG_TSTAMP_EN defined)
//
// Optional feature macro: CAPT_SEG_TSTAMP_EN
// ---------------------------------------------------------------------------
module capture_seg_unit #(
    parameter int ENTRIES      = 384,
    parameter int ADDR_W       = 9,
    parameter int SEG_LOG2_MAX = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic                    abort,
    input  logic                    wrt_smpl,
    input  logic                    triggered,
    input  logic [ADDR_W-1:0]       trig_pos,
    input  logic [1:0]              seg_log2,
    output logic [ADDR_W-1:0]       waddr,
    output logic                    write,
    output logic                    armed,
    output logic                    seg_done,
    output logic [SEG_LOG2_MAX-1:0] cur_seg,
    output logic [ADDR_W-1:0]       trig_addr,
    output logic                    capture_done,
    output logic                    busy
`ifdef CAPT_SEG_TSTAMP_EN
    ,
    output logic [31:0]             seg_tstamp
`endif
);

    // One extra bit so a full-depth single segment length fits.
    localparam int CW = ADDR_W + 1;
    localparam int NW = $clog2(SEG_LOG2_MAX + 1);
    localparam logic [CW-1:0] ONE = CW'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_ARMED = 3'd2;
    localparam logic [2:0] S_POST  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    if (SEG_LOG2_MAX < 1) begin : g_chk_segmax
        $error("SEG_LOG2_MAX must be >= 1");
    end
    if ((ENTRIES % (1 << SEG_LOG2_MAX)) != 0) begin : g_chk_entries
        $error("ENTRIES must be a multiple of 2^SEG_LOG2_MAX");
    end
    if ((1 << ADDR_W) < ENTRIES) begin : g_chk_addr
        $error("ADDR_W too small for ENTRIES");
    end

    logic [2:0]              state;
    logic [CW-1:0]           seg_len;
    logic [CW-1:0]           tp;
    logic [CW-1:0]           th;
    logic [SEG_LOG2_MAX-1:0] last_seg;
    logic [ADDR_W-1:0]       seg_base;
    logic [CW-1:0]           offset;
    logic [CW-1:0]           pre_cnt;
    logic [CW-1:0]           post_cnt;

    // Configuration derived from the live inputs; only used on an accepted run.
    logic [NW-1:0]           nseg_c;
    logic [CW-1:0]           seg_len_c;
    logic [CW-1:0]           tpos_ext;
    logic [CW-1:0]           tp_c;
    logic [CW-1:0]           th_c;
    logic [SEG_LOG2_MAX-1:0] last_c;

    always_comb begin
        if (int'(seg_log2) > SEG_LOG2_MAX) nseg_c = NW'(SEG_LOG2_MAX);
        else                               nseg_c = NW'(seg_log2);
        seg_len_c = CW'(ENTRIES >> nseg_c);
        tpos_ext  = {1'b0, trig_pos};
        tp_c      = (tpos_ext > seg_len_c - ONE) ? seg_len_c - ONE : tpos_ext;
        th_c      = seg_len_c - ONE - tp_c;
        last_c    = SEG_LOG2_MAX'((32'd1 << nseg_c) - 32'd1);
    end

    // Next address inside the current segment, wrapping at the segment end.
    logic [CW-1:0]     adv_offset;
    logic [ADDR_W-1:0] adv_waddr;
    logic              start;
    logic              trig_hit;
    logic              seg_cmp;

    always_comb begin
        adv_offset = (offset == seg_len - ONE) ? '0 : offset + ONE;
        adv_waddr  = seg_base + adv_offset[ADDR_W-1:0];
        start      = run && !abort && (state == S_IDLE || state == S_DONE);
        trig_hit   = !abort && (state == S_ARMED) && wrt_smpl && triggered;
        seg_cmp    = !abort && wrt_smpl &&
                     (((state == S_ARMED) && triggered && (tp == '0)) ||
                      ((state == S_POST) && (post_cnt + ONE == tp)));
    end

    assign busy         = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
    assign write        = wrt_smpl && busy;
    assign armed        = (state == S_ARMED);
    assign capture_done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            seg_len   <= '0;
            tp        <= '0;
            th        <= '0;
            last_seg  <= '0;
            seg_base  <= '0;
            offset    <= '0;
            pre_cnt   <= '0;
            post_cnt  <= '0;
            waddr     <= '0;
            cur_seg   <= '0;
            trig_addr <= '0;
            seg_done  <= 1'b0;
        end else begin
            seg_done <= 1'b0;
            if (abort) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (run) begin
                            seg_len  <= seg_len_c;
                            tp       <= tp_c;
                            th       <= th_c;
                            last_seg <= last_c;
                            seg_base <= '0;
                            offset   <= '0;
                            pre_cnt  <= '0;
                            post_cnt <= '0;
                            waddr    <= '0;
                            cur_seg  <= '0;
                            state    <= (th_c == '0) ? S_ARMED : S_PRE;
                        end
                    end
                    S_PRE: begin
                        if (wrt_smpl) begin
                            offset  <= adv_offset;
                            waddr   <= adv_waddr;
                            pre_cnt <= pre_cnt + ONE;
                            if (pre_cnt + ONE == th) state <= S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        if (wrt_smpl) begin
                            offset <= adv_offset;
                            waddr  <= adv_waddr;
                            if (triggered) begin
                                trig_addr <= waddr;
                                post_cnt  <= '0;
                                state     <= S_POST;
                            end
                        end
                    end
                    S_POST: begin
                        if (wrt_smpl) begin
                            offset   <= adv_offset;
                            waddr    <= adv_waddr;
                            post_cnt <= post_cnt + ONE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase

                // Segment completion overrides the per-state updates above.
                if (seg_cmp) begin
                    seg_done <= 1'b1;
                    if (cur_seg == last_seg) begin
                        state <= S_DONE;
                    end else begin
                        cur_seg  <= cur_seg + 1'b1;
                        seg_base <= seg_base + seg_len[ADDR_W-1:0];
                        waddr    <= seg_base + seg_len[ADDR_W-1:0];
                        offset   <= '0;
                        pre_cnt  <= '0;
                        post_cnt <= '0;
                        state    <= (th == '0) ? S_ARMED : S_PRE;
                    end
                end
            end
        end
    end

`ifdef CAPT_SEG_TSTAMP_EN
    logic [31:0] cyc_cnt;
    logic [31:0] trig_ts;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt    <= '0;
            trig_ts    <= '0;
            seg_tstamp <= '0;
        end else begin
            cyc_cnt <= start ? '0 : cyc_cnt + 32'd1;
            if (trig_hit) trig_ts <= cyc_cnt;
            // With tp == 0 the trigger and completion share one edge.
            if (seg_cmp) seg_tstamp <= trig_hit ? cyc_cnt : trig_ts;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = start ^ trig_hit;
`endif

endmodule

// File: tb/tb_capture_seg_unit.sv
module tb_capture_seg_unit;

    logic       clk;
    logic       rst;
    logic       run;
    logic       abort;
    logic       wrt_smpl;
    logic       triggered;
    logic [8:0] trig_pos;
    logic [1:0] seg_log2;
    logic [8:0] waddr;
    logic       write;
    logic       armed;
    logic       seg_done;
    logic [1:0] cur_seg;
    logic [8:0] trig_addr;
    logic       capture_done;
    logic       busy;
`ifdef CAPT_SEG_TSTAMP_EN
    logic [31:0] seg_tstamp;
`endif

    int checks = 0;
    int errors = 0;

    capture_seg_unit #(.ENTRIES(384), .ADDR_W(9), .SEG_LOG2_MAX(2)) dut (
        .clk(clk), .rst(rst), .run(run), .abort(abort),
        .wrt_smpl(wrt_smpl), .triggered(triggered),
        .trig_pos(trig_pos), .seg_log2(seg_log2),
        .waddr(waddr), .write(write), .armed(armed), .seg_done(seg_done),
        .cur_seg(cur_seg), .trig_addr(trig_addr),
        .capture_done(capture_done), .busy(busy)
`ifdef CAPT_SEG_TSTAMP_EN
        , .seg_tstamp(seg_tstamp)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst, run, abort, wrt, trig;
        logic [8:0] tpos;
        logic [1:0] sl2;
        logic [8:0] e_waddr;
        logic       e_write, e_armed, e_sd;
        logic [1:0] e_cur;
        logic [8:0] e_ta;
        logic       e_cd, e_busy;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic w, input logic t);
        wrt_smpl  = w;
        triggered = t;
        tick();
    endtask

    // Single segment, trig_pos 100, trigger on the 400th sample.
    task automatic seq_single(input string tag);
        int sd_seen;
        seg_log2 = 2'd0; trig_pos = 9'd100; run = 1'b1;
        cyc(1'b0, 1'b0);
        run = 1'b0;
        chk({tag, " start busy"}, busy, 1);
        chk({tag, " start armed"}, armed, 0);
        chk({tag, " start waddr"}, waddr, 0);
        chk({tag, " start cd"}, capture_done, 0);
        for (int i = 0; i < 282; i++) cyc(1'b1, 1'b0);
        chk({tag, " armed after 282"}, armed, 0);
        cyc(1'b1, 1'b0);
        chk({tag, " armed after 283"}, armed, 1);
        chk({tag, " waddr after 283"}, waddr, 283);
        for (int i = 0; i < 116; i++) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        chk({tag, " trig_addr"}, trig_addr, 15);
        chk({tag, " armed after trig"}, armed, 0);
        chk({tag, " waddr after trig"}, waddr, 16);
        sd_seen = 0;
        for (int i = 0; i < 99; i++) begin
            cyc(1'b1, 1'b0);
            if (seg_done) sd_seen++;
        end
        chk({tag, " early seg_done"}, sd_seen, 0);
        cyc(1'b1, 1'b0);
        chk({tag, " seg_done"}, seg_done, 1);
        chk({tag, " capture_done"}, capture_done, 1);
        chk({tag, " final waddr"}, waddr, 116);
        chk({tag, " busy at done"}, busy, 0);
        cyc(1'b1, 1'b0);
        chk({tag, " seg_done pulse"}, seg_done, 0);
        chk({tag, " cd hold"}, capture_done, 1);
        chk({tag, " waddr hold"}, waddr, 116);
        chk({tag, " write in done"}, write, 0);
    endtask

    initial begin
        int sd_seen;
        int out_rng;
        int base;
        rst = 1'b1; run = 1'b0; abort = 1'b0; wrt_smpl = 1'b0; triggered = 1'b0;
        trig_pos = '0; seg_log2 = '0;

        //        rst  run  abt  wrt  trg  tpos     sl2   waddr  wr   arm  sd   cur   ta    cd   busy
        vt[0] = '{1'b1,1'b0,1'b0,1'b0,1'b0,9'd0,   2'd0, 9'd0,  1'b0,1'b0,1'b0,2'd0,9'd0,1'b0,1'b0};
        vt[1] = '{1'b0,1'b0,1'b0,1'b1,1'b1,9'd0,   2'd0, 9'd0,  1'b0,1'b0,1'b0,2'd0,9'd0,1'b0,1'b0};
        vt[2] = '{1'b0,1'b1,1'b0,1'b0,1'b0,9'd500, 2'd1, 9'd0,  1'b0,1'b1,1'b0,2'd0,9'd0,1'b0,1'b1};
        vt[3] = '{1'b0,1'b0,1'b0,1'b1,1'b1,9'd0,   2'd0, 9'd1,  1'b1,1'b0,1'b0,2'd0,9'd0,1'b0,1'b1};
        vt[4] = '{1'b0,1'b0,1'b0,1'b1,1'b0,9'd0,   2'd0, 9'd2,  1'b1,1'b0,1'b0,2'd0,9'd0,1'b0,1'b1};
        vt[5] = '{1'b0,1'b1,1'b0,1'b0,1'b1,9'd0,   2'd0, 9'd2,  1'b0,1'b0,1'b0,2'd0,9'd0,1'b0,1'b1};
        vt[6] = '{1'b0,1'b0,1'b0,1'b1,1'b0,9'd0,   2'd0, 9'd3,  1'b1,1'b0,1'b0,2'd0,9'd0,1'b0,1'b1};
        vt[7] = '{1'b0,1'b0,1'b0,1'b1,1'b0,9'd0,   2'd0, 9'd4,  1'b1,1'b0,1'b0,2'd0,9'd0,1'b0,1'b1};

        for (int i = 0; i < 8; i++) begin
            rst = vt[i].rst; run = vt[i].run; abort = vt[i].abort;
            wrt_smpl = vt[i].wrt; triggered = vt[i].trig;
            trig_pos = vt[i].tpos; seg_log2 = vt[i].sl2;
            tick();
            chk($sformatf("v%0d waddr", i), waddr, vt[i].e_waddr);
            chk($sformatf("v%0d write", i), write, vt[i].e_write);
            chk($sformatf("v%0d armed", i), armed, vt[i].e_armed);
            chk($sformatf("v%0d seg_done", i), seg_done, vt[i].e_sd);
            chk($sformatf("v%0d cur_seg", i), cur_seg, vt[i].e_cur);
            chk($sformatf("v%0d trig_addr", i), trig_addr, vt[i].e_ta);
            chk($sformatf("v%0d capture_done", i), capture_done, vt[i].e_cd);
            chk($sformatf("v%0d busy", i), busy, vt[i].e_busy);
        end
        run = 1'b0;

        // Clamped tp = 191: three post writes so far, 188 more to go.
        sd_seen = 0;
        for (int i = 0; i < 187; i++) begin
            cyc(1'b1, 1'b0);
            if (seg_done) sd_seen++;
        end
        chk("clamp early seg_done", sd_seen, 0);
        cyc(1'b1, 1'b0);
        chk("clamp seg_done", seg_done, 1);
        chk("clamp cur_seg", cur_seg, 1);
        chk("clamp waddr", waddr, 192);
        chk("clamp armed", armed, 1);
        chk("clamp trig_addr", trig_addr, 0);
        chk("clamp capture_done", capture_done, 0);

        // Abort together with run in POST of segment 1.
        cyc(1'b1, 1'b1);
        chk("seg1 trig_addr", trig_addr, 192);
        chk("seg1 seg_done cleared", seg_done, 0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        chk("seg1 waddr", waddr, 195);
        abort = 1'b1; run = 1'b1;
        cyc(1'b1, 1'b0);
        chk("abort busy", busy, 0);
        chk("abort write", write, 0);
        chk("abort armed", armed, 0);
        chk("abort seg_done", seg_done, 0);
        chk("abort capture_done", capture_done, 0);
        abort = 1'b0; run = 1'b0;
        cyc(1'b0, 1'b0);
        chk("after abort seg_done", seg_done, 0);
        chk("after abort busy", busy, 0);

        // Trigger held high through PRE, tp = 0.
        seg_log2 = 2'd0; trig_pos = 9'd0; run = 1'b1;
        cyc(1'b0, 1'b1);
        run = 1'b0;
        chk("hold start busy", busy, 1);
        chk("hold start armed", armed, 0);
        for (int i = 0; i < 382; i++) cyc(1'b1, 1'b1);
        chk("hold armed 382", armed, 0);
        chk("hold seg_done 382", seg_done, 0);
        cyc(1'b1, 1'b1);
        chk("hold armed 383", armed, 1);
        chk("hold waddr 383", waddr, 383);
        chk("hold seg_done 383", seg_done, 0);
        cyc(1'b1, 1'b1);
        chk("hold seg_done", seg_done, 1);
        chk("hold capture_done", capture_done, 1);
        chk("hold trig_addr", trig_addr, 383);
        chk("hold waddr wrap", waddr, 0);
        chk("hold armed done", armed, 0);

        // Four segments from DONE, trig_pos 10: SEG_LEN 96, TH 85.
        seg_log2 = 2'd2; trig_pos = 9'd10; run = 1'b1;
        cyc(1'b0, 1'b0);
        run = 1'b0;
        chk("quad start cd", capture_done, 0);
        chk("quad start busy", busy, 1);
        chk("quad start waddr", waddr, 0);
        for (int s = 0; s < 4; s++) begin
            base = s * 96;
            out_rng = 0;
            chk($sformatf("quad%0d cur_seg", s), cur_seg, s);
            for (int i = 0; i < 85; i++) begin
                cyc(1'b1, 1'b0);
                if (waddr < base || waddr > base + 95) out_rng++;
            end
            chk($sformatf("quad%0d armed", s), armed, 1);
            cyc(1'b1, 1'b1);
            chk($sformatf("quad%0d trig_addr", s), trig_addr, base + 85);
            for (int i = 0; i < 9; i++) begin
                cyc(1'b1, 1'b0);
                if (waddr < base || waddr > base + 95) out_rng++;
            end
            chk($sformatf("quad%0d range", s), out_rng, 0);
            chk($sformatf("quad%0d early sd", s), seg_done, 0);
            cyc(1'b1, 1'b0);
            chk($sformatf("quad%0d seg_done", s), seg_done, 1);
            chk($sformatf("quad%0d cd", s), capture_done, (s == 3) ? 1 : 0);
            chk($sformatf("quad%0d next waddr", s), waddr, (s == 3) ? 288 : base + 96);
        end

        // Reset while ARMED, then a full run as from power-up.
        seg_log2 = 2'd1; trig_pos = 9'd191; run = 1'b1;
        cyc(1'b0, 1'b0);
        run = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
        chk("pre-rst armed", armed, 1);
        chk("pre-rst waddr", waddr, 3);
        rst = 1'b1;
        cyc(1'b1, 1'b0);
        chk("rst waddr", waddr, 0);
        chk("rst write", write, 0);
        chk("rst armed", armed, 0);
        chk("rst busy", busy, 0);
        chk("rst cur_seg", cur_seg, 0);
        chk("rst trig_addr", trig_addr, 0);
        chk("rst cd", capture_done, 0);
        chk("rst seg_done", seg_done, 0);
        rst = 1'b0;
        cyc(1'b0, 1'b0);
        seq_single("post-rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
